// File: rtl/decode_stage_pkg.sv
// -----------------------------------------------------------------------------
// decode_stage_pkg
// Shared definitions for the decode stage:
//   - opcode constants for the supported instruction classes
//   - ALUControl and ResultSrc encodings driven toward the execute stage
//   - imm_src_t, which selects the immediate format (I, S, B, J)
//   - ctrl_t, the bundle of control signals produced by the main decoder
// Optional feature macro used by the slice: DECODE_WB_BYPASS_EN (see reg_file).
// -----------------------------------------------------------------------------
package decode_stage_pkg;

  // Opcodes (InstrD[6:0])
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // ALUControl encodings
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // ResultSrc encodings
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // Immediate format selector
  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_t;

  // Control bundle carried from decode into the decode/execute register
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic [1:0] result_src;
    logic [2:0] alu_control;
  } ctrl_t;

endpackage

// File: rtl/decode_stage_reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
// 32 x 32-bit register file, two asynchronous read ports, one synchronous
// write port. x0 always reads as zero and writes to it are dropped.
// Every entry clears asynchronously while rst is low.
//
// Configuration macro: DECODE_WB_BYPASS_EN
//   defined   : a read of the register being written this cycle returns wd
//               (write-through)
//   undefined : such a read returns the value held before the write
//
// Ports:
//   clk  in  1   clock
//   rst  in  1   asynchronous active-low reset
//   ra1  in  5   read address, port 1
//   ra2  in  5   read address, port 2
//   rd1  out 32  read data, port 1
//   rd2  out 32  read data, port 2
//   we   in  1   write enable
//   wa   in  5   write address
//   wd   in  32  write data
// -----------------------------------------------------------------------------
module reg_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] regs [32];
  logic        wr_valid;

  assign wr_valid = we && (wa != 5'd0);

  // Async reset also kills a writeback that lands in the reset cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_valid) begin
      regs[wa] <= wd;
    end
  end

  always_comb begin
    rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
    rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];
`ifdef DECODE_WB_BYPASS_EN
    // wr_valid already excludes x0, so the zero register stays zero.
    if (wr_valid && (wa == ra1)) rd1 = wd;
    if (wr_valid && (wa == ra2)) rd2 = wd;
`endif
  end

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
// Decode stage of a 5-stage RV32 subset pipeline (R-type, I-ALU, lw, sw, beq,
// jal). Decodes InstrD into control signals and a sign-extended immediate,
// reads two source operands from the register file (reg_file) and registers
// everything into the decode/execute register. Unsupported opcodes decode as
// a NOP. FlushE zeroes the whole decode/execute register on the next edge.
//
// Configuration macro: DECODE_WB_BYPASS_EN (write-through inside reg_file).
//
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   InstrD, PCD, PCPlus4D        instruction, its PC and PC+4 (decode)
//   FlushE                       load a bubble into the execute register
//   RegWriteW, RdW, ResultW      writeback port into the register file
//   RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE   registered controls
//   ResultSrcE[1:0]              00 ALU, 01 memory, 10 PC+4
//   ALUControlE[2:0]             000 add, 001 sub, 010 and, 011 or, 101 slt
//   RD1E, RD2E, ImmExtE, PCE, PCPlus4E   registered operands
//   Rs1E, Rs2E, RdE              registered register indices
// -----------------------------------------------------------------------------
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        FlushE,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        BranchE,
  output logic        JumpE,
  output logic        ALUSrcE,
  output logic [1:0]  ResultSrcE,
  output logic [2:0]  ALUControlE,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E,
  output logic [4:0]  RdE
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_b5;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;

  assign opcode    = InstrD[6:0];
  assign funct3    = InstrD[14:12];
  assign funct7_b5 = InstrD[30];
  assign rs1       = InstrD[19:15];
  assign rs2       = InstrD[24:20];
  assign rd        = InstrD[11:7];

  ctrl_t       ctrl_d;
  imm_src_t    imm_src;
  logic        alu_from_funct;
  logic        is_rtype;
  logic [31:0] imm_ext;
  logic [31:0] rd1_d;
  logic [31:0] rd2_d;

  // ---------------------------------------------------------------------------
  // Main decoder + ALU decoder
  // ---------------------------------------------------------------------------
  always_comb begin
    ctrl_d         = '0;
    imm_src        = IMM_I;
    alu_from_funct = 1'b0;
    is_rtype       = 1'b0;

    case (opcode)
      OP_RTYPE: begin
        ctrl_d.reg_write = 1'b1;
        alu_from_funct   = 1'b1;
        is_rtype         = 1'b1;
      end
      OP_IALU: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        alu_from_funct   = 1'b1;
      end
      OP_LOAD: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.result_src = RES_MEM;
      end
      OP_STORE: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        imm_src          = IMM_S;
      end
      OP_BRANCH: begin
        ctrl_d.branch      = 1'b1;
        ctrl_d.alu_control = ALU_SUB;
        imm_src            = IMM_B;
      end
      OP_JAL: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.jump       = 1'b1;
        ctrl_d.result_src = RES_PC4;
        imm_src           = IMM_J;
      end
      default: begin
        // Unknown opcode: leave the all-zero NOP bundle.
      end
    endcase

    // funct7[5] means sub only for register-register ops; for I-ALU the same
    // bit is part of the immediate, so addi must never turn into sub.
    if (alu_from_funct) begin
      case (funct3)
        3'b000:  ctrl_d.alu_control = (is_rtype && funct7_b5) ? ALU_SUB : ALU_ADD;
        3'b010:  ctrl_d.alu_control = ALU_SLT;
        3'b110:  ctrl_d.alu_control = ALU_OR;
        3'b111:  ctrl_d.alu_control = ALU_AND;
        default: ctrl_d.alu_control = ALU_ADD;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Immediate extension (always sign-extended from InstrD[31])
  // ---------------------------------------------------------------------------
  always_comb begin
    imm_ext = '0;
    case (imm_src)
      IMM_I:   imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
      IMM_S:   imm_ext = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B:   imm_ext = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25],
                          InstrD[11:8], 1'b0};
      IMM_J:   imm_ext = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20],
                          InstrD[30:21], 1'b0};
      default: imm_ext = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  reg_file u_reg_file (
    .clk (clk),
    .rst (rst),
    .ra1 (rs1),
    .ra2 (rs2),
    .rd1 (rd1_d),
    .rd2 (rd2_d),
    .we  (RegWriteW),
    .wa  (RdW),
    .wd  (ResultW)
  );

  // ---------------------------------------------------------------------------
  // Decode/execute register. Flush only clears this register; the register
  // file write above is independent and still happens on the same edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      BranchE     <= 1'b0;
      JumpE       <= 1'b0;
      ALUSrcE     <= 1'b0;
      ResultSrcE  <= 2'b00;
      ALUControlE <= 3'b000;
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
    end else if (FlushE) begin
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      BranchE     <= 1'b0;
      JumpE       <= 1'b0;
      ALUSrcE     <= 1'b0;
      ResultSrcE  <= 2'b00;
      ALUControlE <= 3'b000;
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
    end else begin
      RegWriteE   <= ctrl_d.reg_write;
      MemWriteE   <= ctrl_d.mem_write;
      BranchE     <= ctrl_d.branch;
      JumpE       <= ctrl_d.jump;
      ALUSrcE     <= ctrl_d.alu_src;
      ResultSrcE  <= ctrl_d.result_src;
      ALUControlE <= ctrl_d.alu_control;
      RD1E        <= rd1_d;
      RD2E        <= rd2_d;
      ImmExtE     <= imm_ext;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
      Rs1E        <= rs1;
      Rs2E        <= rs2;
      RdE         <= rd;
    end
  end

endmodule
